spi_master_ctrl: RTL and testbench
==================================

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 Parameter DWIDTH, default 32, data-phase width in bits.
REQ-002 Parameter AWIDTH, default 12, byte-address width of the slave memory (4 KiB).
REQ-003 Parameter NSLAVES, default 4, number of chip selects.
REQ-004 Parameter S_ADDR_WIDTH, default $clog2(NSLAVES), slave-select index width.
REQ-005 Parameter CLK_DIV, default 2, legal range 1 or more, SCLK half-period in clk cycles.
REQ-006 Port clk, input, 1, the single system clock; all logic SHALL be clocked on its rising edge.
REQ-007 Port rst, input, 1, synchronous active-high reset.
REQ-008 Port cmd_valid, input, 1, command present.
REQ-009 Port cmd_ready, output, 1, command accepted when both cmd_valid and cmd_ready are high on a clk edge.
REQ-010 Port cmd_rw, input, 1, 1 = write, 0 = read.
REQ-011 Port cmd_slave, input, S_ADDR_WIDTH, target slave index.
REQ-012 Port cmd_addr, input, AWIDTH, slave byte address.
REQ-013 Port cmd_wdata, input, DWIDTH, write data (ignored for reads).
REQ-014 Port rsp_valid, output, 1, one-cycle completion pulse.
REQ-015 Port rsp_rdata, output, DWIDTH, read data, valid with rsp_valid.
REQ-016 Port rsp_err, output, 1, invalid slave index, valid with rsp_valid.
REQ-017 Port busy, output, 1, transaction in progress.
REQ-018 Ports sclk (output, 1), mosi (output, 1), miso (input, 1) and cs_n (output, NSLAVES, active low) form the SPI bus.

Function
REQ-019 Frame SHALL be FRAME = 1+AWIDTH+DWIDTH bits, sent MSB first: cmd_rw, then cmd_addr, then data (cmd_wdata for writes, zeros for reads).
REQ-020 SPI mode 0: sclk idles low; mosi changes only while sclk is low; miso is sampled on the clk edge where sclk goes 0->1.
REQ-021 FSM states SHALL be IDLE -> SHIFT -> HOLD -> DONE -> IDLE.
REQ-022 IDLE: cmd_ready=1 and busy=0; on accept, all command fields are latched and the next state is SHIFT.
REQ-023 SHIFT: cs_n[cmd_slave] is low; each bit is sclk low for CLK_DIV cycles, then high for CLK_DIV cycles; the bit counter runs 0..FRAME-1; after the last high half, sclk returns low and the next state is HOLD.
REQ-024 HOLD: cs_n is held low and sclk low for CLK_DIV cycles, then the next state is DONE.
REQ-025 DONE: all cs_n are high; rsp_valid=1 for exactly this one cycle; the next state is IDLE.
REQ-026 Latency: with the accept edge at cycle T, cs_n asserts in cycle T+1 and rsp_valid is high in cycle T+1+(2*FRAME+1)*CLK_DIV (T+183 with the defaults).
REQ-027 Reads: the last DWIDTH miso samples, MSB first, form rsp_rdata.
REQ-028 Writes: rsp_rdata=0.
REQ-029 rsp_rdata holds its value until the next rsp_valid.
REQ-030 If cmd_slave >= NSLAVES, the frame timing is unchanged, all cs_n stay high, and rsp_err=1 with rsp_rdata=0; otherwise rsp_err=0.
REQ-031 cmd_ready is 0 in SHIFT, HOLD and DONE; command inputs are ignored in those states.
REQ-032 A new command SHALL be acceptable in the cycle after DONE, so all cs_n are high for at least 1 cycle between frames.
REQ-033 Exactly FRAME sclk rising edges occur per transaction, and none occur outside SHIFT.
REQ-034 At most one cs_n bit is low at any time.

Reset
REQ-035 While rst is high on a clk edge: state=IDLE, sclk=0, mosi=0, cs_n all 1, cmd_ready=0, busy=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, bit and divider counters=0.
REQ-036 cmd_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-037 Reset during SHIFT or HOLD aborts the frame with no rsp_valid; the command is discarded.

Verification
REQ-038 Write: slave 2, addr 0x004, data 0xDEADBEEF, defaults -> cs_n=4'b1011 for 182 cycles; mosi bit stream = 1, 0x004, 0xDEADBEEF; rsp_valid at T+183; rsp_rdata=0; rsp_err=0.
REQ-039 Read: slave 0, addr 0xFFC, slave model returns 0xA5A50F0F -> rsp_rdata=0xA5A50F0F; mosi data-phase bits all 0; cs_n=4'b1110.
REQ-040 Back-to-back: cmd_valid held high with two commands -> second accepted at T+184; all cs_n high in cycle T+183; 45 sclk rising edges per frame.
REQ-041 Reset mid-frame: rst pulsed at T+50 -> next cycle cs_n=4'hF, sclk=0, busy=0; no rsp_valid follows; cmd_ready=1 after release.
REQ-042 Invalid slave: NSLAVES=3, cmd_slave=3 -> cs_n=3'b111 for the whole frame; rsp_valid at the nominal cycle with rsp_err=1 and rsp_rdata=0.
REQ-043 CLK_DIV=1 write -> sclk toggles every cycle; rsp_valid at T+92; mosi stable whenever sclk is high.

Source files
------------

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master controller.
// Sends one frame per command: {rw, addr, data} MSB first on mosi while
// collecting miso, then reports completion with a one-cycle rsp_valid pulse.
// Frame sequencing runs IDLE -> SHIFT -> HOLD -> DONE -> IDLE.
// All bus and handshake outputs come straight from registers.
module spi_master_ctrl #(
  parameter int DWIDTH       = 32,
  parameter int AWIDTH       = 12,
  parameter int NSLAVES      = 4,
  parameter int S_ADDR_WIDTH = $clog2(NSLAVES),
  parameter int CLK_DIV      = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_rw,
  input  logic [S_ADDR_WIDTH-1:0] cmd_slave,
  input  logic [AWIDTH-1:0]       cmd_addr,
  input  logic [DWIDTH-1:0]       cmd_wdata,
  output logic                    rsp_valid,
  output logic [DWIDTH-1:0]       rsp_rdata,
  output logic                    rsp_err,
  output logic                    busy,
  output logic                    sclk,
  output logic                    mosi,
  input  logic                    miso,
  output logic [NSLAVES-1:0]      cs_n
);

  localparam int FRAME = 1 + AWIDTH + DWIDTH;
  localparam int BW    = $clog2(FRAME);
  localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME - 1);
  localparam logic [DW-1:0] LAST_DIV = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD,
    DONE
  } state_t;

  state_t              state_q;
  logic [BW-1:0]       bit_cnt_q;
  logic [DW-1:0]       div_cnt_q;
  logic                sclk_q;
  logic [NSLAVES-1:0]  cs_n_q;
  logic                cmd_ready_q;
  logic                busy_q;
  logic                rsp_valid_q;
  logic                rsp_err_q;
  logic [DWIDTH-1:0]   rsp_rdata_q;
  logic [FRAME-1:0]    tx_q;       // outgoing frame, MSB drives mosi
  logic [DWIDTH-1:0]   rx_q;       // last DWIDTH miso samples
  logic                rw_q;
  logic                err_q;

  logic [FRAME-1:0]    frame_d;
  logic                slave_ok_d;
  logic [NSLAVES-1:0]  cs_n_d;
  logic [DWIDTH-1:0]   rx_d;
  logic [DWIDTH-1:0]   rdata_d;

  // Decode the incoming command and the datapath next values.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    frame_d    = {cmd_rw, cmd_addr, (cmd_rw ? cmd_wdata : {DWIDTH{1'b0}})};
    slave_ok_d = (int'(cmd_slave) < NSLAVES);
    cs_n_d     = '1;
    for (int i = 0; i < NSLAVES; i++) begin
      if (slave_ok_d && (int'(cmd_slave) == i)) cs_n_d[i] = 1'b0;
    end
    rx_d       = {rx_q[DWIDTH-2:0], miso};
    rdata_d    = (!rw_q && !err_q) ? rx_q : '0;
  end

  // Frame sequencer: state, SCLK divider, shift registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the shift registers are ordinary flops, so clearing them here is cheap and keeps mosi/rsp_rdata defined after reset.
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      div_cnt_q   <= '0;
      sclk_q      <= 1'b0;
      cs_n_q      <= '1;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      rw_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register update from pre-edge values, regardless of statement order.
      case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          rsp_valid_q <= 1'b0;
          if (cmd_valid && cmd_ready_q) begin
            state_q     <= SHIFT;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            tx_q        <= frame_d;
            rw_q        <= cmd_rw;
            err_q       <= !slave_ok_d;
            cs_n_q      <= cs_n_d;
            bit_cnt_q   <= '0;
            div_cnt_q   <= '0;
            sclk_q      <= 1'b0;
          end
        end

        SHIFT: begin
          if (div_cnt_q != LAST_DIV) begin
            div_cnt_q <= div_cnt_q + DW'(1);
          end else begin
            div_cnt_q <= '0;
            if (!sclk_q) begin
              // Rising SCLK edge: the slave samples mosi, we sample miso.
              sclk_q <= 1'b1;
              rx_q   <= rx_d;
            end else begin
              // Falling SCLK edge: advance to the next bit or finish the frame.
              sclk_q <= 1'b0;
              if (bit_cnt_q == LAST_BIT) begin
                state_q <= HOLD;
                tx_q    <= '0;
              end else begin
                bit_cnt_q <= bit_cnt_q + BW'(1);
                tx_q      <= {tx_q[FRAME-2:0], 1'b0};
              end
            end
          end
        end

        HOLD: begin
          if (div_cnt_q != LAST_DIV) begin
            div_cnt_q <= div_cnt_q + DW'(1);
          end else begin
            div_cnt_q   <= '0;
            state_q     <= DONE;
            cs_n_q      <= '1;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= err_q;
            rsp_rdata_q <= rdata_d;
          end
        end

        DONE: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          bit_cnt_q   <= '0;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign sclk      = sclk_q;
  assign mosi      = tx_q[FRAME-1];
  assign cs_n      = cs_n_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl.
// Three instances share the command bus and miso: default parameters,
// NSLAVES=3 and CLK_DIV=1. Only the selected instance sees cmd_valid.
// A cycle-level reference derived from the frame rules predicts sclk,
// cs_n, the mosi bit stream, latency and response fields.
module tb_spi_master_ctrl;

  localparam int FRAME = 45;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  cv;
  logic        cmd_rw;
  logic [1:0]  cmd_slave;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        miso;

  logic        rdy0, vld0, err0, bsy0, sck0, mo0;
  logic        rdy1, vld1, err1, bsy1, sck1, mo1;
  logic        rdy2, vld2, err2, bsy2, sck2, mo2;
  logic [31:0] rd0, rd1, rd2;
  logic [3:0]  cs0, cs2;
  logic [2:0]  cs1;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int sel    = 0;

  logic        nxt_rw;
  logic [1:0]  nxt_slave;
  logic [11:0] nxt_addr;
  logic [31:0] nxt_wdata;

  logic        m_rdy, m_vld, m_err, m_bsy, m_sck, m_mo;
  logic [31:0] m_rd;
  logic [3:0]  m_cs;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_master_ctrl dut0 (
    .clk(clk), .rst(rst), .cmd_valid(cv[0]), .cmd_ready(rdy0), .cmd_rw(cmd_rw),
    .cmd_slave(cmd_slave), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(vld0), .rsp_rdata(rd0), .rsp_err(err0), .busy(bsy0),
    .sclk(sck0), .mosi(mo0), .miso(miso), .cs_n(cs0)
  );

  spi_master_ctrl #(.NSLAVES(3)) dut1 (
    .clk(clk), .rst(rst), .cmd_valid(cv[1]), .cmd_ready(rdy1), .cmd_rw(cmd_rw),
    .cmd_slave(cmd_slave), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(vld1), .rsp_rdata(rd1), .rsp_err(err1), .busy(bsy1),
    .sclk(sck1), .mosi(mo1), .miso(miso), .cs_n(cs1)
  );

  spi_master_ctrl #(.CLK_DIV(1)) dut2 (
    .clk(clk), .rst(rst), .cmd_valid(cv[2]), .cmd_ready(rdy2), .cmd_rw(cmd_rw),
    .cmd_slave(cmd_slave), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(vld2), .rsp_rdata(rd2), .rsp_err(err2), .busy(bsy2),
    .sclk(sck2), .mosi(mo2), .miso(miso), .cs_n(cs2)
  );

  // Route the selected instance to a common set of observation signals.
  always_comb begin
    m_rdy = rdy0; m_vld = vld0; m_err = err0; m_bsy = bsy0;
    m_sck = sck0; m_mo = mo0; m_rd = rd0; m_cs = cs0;
    case (sel)
      1: begin
        m_rdy = rdy1; m_vld = vld1; m_err = err1; m_bsy = bsy1;
        m_sck = sck1; m_mo = mo1; m_rd = rd1; m_cs = {1'b1, cs1};
      end
      2: begin
        m_rdy = rdy2; m_vld = vld2; m_err = err2; m_bsy = bsy2;
        m_sck = sck2; m_mo = mo2; m_rd = rd2; m_cs = cs2;
      end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame the slave should see on mosi.
  function automatic logic [FRAME-1:0] frame_of(input logic rw, input logic [11:0] addr,
                                                input logic [31:0] wd);
    return {rw, addr, (rw ? wd : 32'h0)};
  endfunction

  function automatic logic [3:0] cs_of(input logic [1:0] slv, input int nsl);
    logic [3:0] v;
    v = 4'hF;
    if (int'(slv) < nsl) v[slv] = 1'b0;
    return v;
  endfunction

  // Present a command and wait (bounded) for the cycle in which it is accepted.
  task automatic issue(input logic rw, input logic [1:0] slv, input logic [11:0] addr,
                       input logic [31:0] wd, output int t_acc);
    cmd_rw = rw; cmd_slave = slv; cmd_addr = addr; cmd_wdata = wd;
    cv[sel] = 1'b1;
    t_acc = -1;
    for (int i = 0; i < 400; i++) begin
      if (m_rdy === 1'b1) begin
        t_acc = cyc;
        break;
      end
      @(negedge clk);
    end
    check("cmd_accepted", 64'(t_acc >= 0), 64'd1);
  endtask

  // Follow one frame cycle by cycle from the accept edge, acting as the slave.
  task automatic run_txn(input int t_acc, input bit keep, input logic [FRAME-1:0] exp_frame,
                         input logic [FRAME-1:0] resp, input logic [31:0] exp_rdata,
                         input logic exp_err, input logic [3:0] exp_cs, input int div);
    int lat = (2 * FRAME + 1) * div;
    int rises = 0;
    int rsp_k = -1;
    int bad_sclk = 0, bad_ctl = 0, bad_cs = 0, bad_mosi = 0;
    logic [FRAME-1:0] cap = '0;
    logic prev_s, prev_m, exp_s;
    logic [31:0] rsp_rd = 'x;
    logic rsp_er = 1'bx;
    logic [3:0] cs_at_rsp = 'x;
    prev_s = m_sck;
    prev_m = m_mo;
    for (int k = 1; k <= lat + 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (!keep) cv[sel] = 1'b0;
        else begin
          cmd_rw = nxt_rw; cmd_slave = nxt_slave; cmd_addr = nxt_addr; cmd_wdata = nxt_wdata;
        end
      end
      if (m_sck && !prev_s) begin
        if (rises < FRAME) cap[FRAME-1-rises] = m_mo;
        rises++;
      end
      if ((m_mo !== prev_m) && (m_sck !== 1'b0)) bad_mosi++;
      if (m_vld === 1'b1) begin
        rsp_k = k; rsp_rd = m_rd; rsp_er = m_err; cs_at_rsp = m_cs;
        break;
      end
      exp_s = (k <= 2 * FRAME * div) ? (((k - 1) / div) % 2 == 1) : 1'b0;
      if (m_sck !== exp_s) bad_sclk++;
      if ((m_cs !== exp_cs) || (m_rdy !== 1'b0) || (m_bsy !== 1'b1)) bad_ctl++;
      if ($countones(~m_cs) > 1) bad_cs++;
      if ((m_sck === 1'b0) && (rises < FRAME)) miso = resp[FRAME-1-rises];
      prev_s = m_sck;
      prev_m = m_mo;
    end
    check("rsp_cycle", 64'(rsp_k), 64'(lat + 1));
    check("sclk_rises", 64'(rises), 64'(FRAME));
    check("mosi_frame", 64'(cap), 64'(exp_frame));
    check("rsp_rdata", 64'(rsp_rd), 64'(exp_rdata));
    check("rsp_err", 64'(rsp_er), 64'(exp_err));
    check("cs_high_at_done", 64'(cs_at_rsp), 64'hF);
    check("sclk_wave", 64'(bad_sclk), 64'd0);
    check("frame_ctl", 64'(bad_ctl), 64'd0);
    check("cs_single_low", 64'(bad_cs), 64'd0);
    check("mosi_stable", 64'(bad_mosi), 64'd0);
    @(negedge clk);
    check("rsp_one_cycle", 64'(m_vld), 64'd0);
    check("ready_after_done", 64'(m_rdy), 64'd1);
    check("rdata_hold", 64'(m_rd), 64'(exp_rdata));
    check("sclk_idle", 64'(m_sck), 64'd0);
  endtask

  // Random command plus slave response, checked against the reference rules.
  task automatic rand_txn(input int nsl, input int div);
    logic rw;
    logic [1:0] slv;
    logic [11:0] addr;
    logic [31:0] wd;
    logic [FRAME-1:0] resp;
    logic ok;
    int t;
    rw   = 1'($urandom);
    slv  = 2'($urandom_range(nsl - 1, 0));
    addr = 12'($urandom);
    wd   = $urandom;
    resp = {13'($urandom), $urandom};
    ok   = (int'(slv) < nsl);
    issue(rw, slv, addr, wd, t);
    run_txn(t, 1'b0, frame_of(rw, addr, wd), resp, (!rw && ok) ? resp[31:0] : 32'h0,
            !ok, cs_of(slv, nsl), div);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tA, tB, t, nvld;
    logic rwA, rwB;
    logic [1:0] sA, sB;
    logic [11:0] aA, aB;
    logic [31:0] dA, dB;
    logic [FRAME-1:0] rA, rB, rr;

    cv = '0; cmd_rw = 1'b0; cmd_slave = '0; cmd_addr = '0; cmd_wdata = '0; miso = 1'b0;
    sel = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_cs_n", 64'(m_cs), 64'hF);
    check("rst_sclk", 64'(m_sck), 64'd0);
    check("rst_mosi", 64'(m_mo), 64'd0);
    check("rst_ready", 64'(m_rdy), 64'd0);
    check("rst_busy", 64'(m_bsy), 64'd0);
    check("rst_rsp_valid", 64'(m_vld), 64'd0);
    check("rst_rsp_err", 64'(m_err), 64'd0);
    check("rst_rsp_rdata", 64'(m_rd), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 64'(m_rdy), 64'd1);
    check("busy_idle", 64'(m_bsy), 64'd0);

    // Directed write: slave 2, addr 0x004, data 0xDEADBEEF.
    issue(1'b1, 2'd2, 12'h004, 32'hDEADBEEF, t);
    rr = {13'($urandom), $urandom};
    run_txn(t, 1'b0, frame_of(1'b1, 12'h004, 32'hDEADBEEF), rr, 32'h0, 1'b0, 4'b1011, 2);

    // Directed read: slave 0, addr 0xFFC, slave returns 0xA5A50F0F.
    issue(1'b0, 2'd0, 12'hFFC, 32'h12345678, t);
    rr = {13'($urandom), 32'hA5A50F0F};
    run_txn(t, 1'b0, frame_of(1'b0, 12'hFFC, 32'h0), rr, 32'hA5A50F0F, 1'b0, 4'b1110, 2);

    // Back-to-back: cmd_valid stays high across two commands.
    rwA = 1'($urandom); sA = 2'($urandom); aA = 12'($urandom); dA = $urandom;
    rwB = ~rwA;         sB = 2'($urandom); aB = 12'($urandom); dB = $urandom;
    rA = {13'($urandom), $urandom};
    rB = {13'($urandom), $urandom};
    nxt_rw = rwB; nxt_slave = sB; nxt_addr = aB; nxt_wdata = dB;
    issue(rwA, sA, aA, dA, tA);
    run_txn(tA, 1'b1, frame_of(rwA, aA, dA), rA, rwA ? 32'h0 : rA[31:0], 1'b0, cs_of(sA, 4), 2);
    issue(rwB, sB, aB, dB, tB);
    check("b2b_accept_cycle", 64'(tB - tA), 64'd184);
    run_txn(tB, 1'b0, frame_of(rwB, aB, dB), rB, rwB ? 32'h0 : rB[31:0], 1'b0, cs_of(sB, 4), 2);

    // Random traffic on the default instance.
    for (int i = 0; i < 3; i++) rand_txn(4, 2);

    // Reset pulsed mid-frame aborts the transaction.
    issue(1'b1, 2'd1, 12'($urandom), $urandom, t);
    @(negedge clk);
    cv[sel] = 1'b0;
    while (cyc < t + 50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_cs_n", 64'(m_cs), 64'hF);
    check("abort_sclk", 64'(m_sck), 64'd0);
    check("abort_busy", 64'(m_bsy), 64'd0);
    @(negedge clk);
    check("abort_ready_after", 64'(m_rdy), 64'd1);
    nvld = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (m_vld === 1'b1) nvld++;
    end
    check("abort_no_rsp", 64'(nvld), 64'd0);

    // NSLAVES=3: invalid slave index 3, then a valid read.
    sel = 1;
    @(negedge clk);
    issue(1'b0, 2'd3, 12'($urandom), $urandom, t);
    rr = {13'($urandom), $urandom};
    run_txn(t, 1'b0, frame_of(1'b0, cmd_addr, 32'h0), rr, 32'h0, 1'b1, 4'hF, 2);
    issue(1'b0, 2'd1, 12'h0A0, 32'h0, t);
    rr = {13'($urandom), $urandom};
    run_txn(t, 1'b0, frame_of(1'b0, 12'h0A0, 32'h0), rr, rr[31:0], 1'b0, 4'b1101, 2);

    // CLK_DIV=1: directed write then random traffic.
    sel = 2;
    @(negedge clk);
    issue(1'b1, 2'd3, 12'h7E1, 32'h0F1E2D3C, t);
    rr = {13'($urandom), $urandom};
    run_txn(t, 1'b0, frame_of(1'b1, 12'h7E1, 32'h0F1E2D3C), rr, 32'h0, 1'b0, 4'b0111, 1);
    for (int i = 0; i < 2; i++) rand_txn(4, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
